// File: rtl/mem_stage_ctrl_if.sv
// Data-bus interface between the MEM stage and the memory system.
//  master: MEM stage (drives req/we/be/addr/wdata, receives ack/rdata)
//  slave : memory side
//  dbus_req   bus request, held until ack or timeout
//  dbus_we    1 = store
//  dbus_be    byte enables, bit i = byte lane i (little-endian)
//  dbus_addr  word address, low two bits always 0
//  dbus_wdata lane-replicated store data
//  dbus_ack   access complete, rdata valid in the same cycle
//  dbus_rdata read data
interface mem_stage_ctrl_if;
  logic        dbus_req;
  logic        dbus_we;
  logic [3:0]  dbus_be;
  logic [31:0] dbus_addr;
  logic [31:0] dbus_wdata;
  logic        dbus_ack;
  logic [31:0] dbus_rdata;

  modport master (
    output dbus_req, dbus_we, dbus_be, dbus_addr, dbus_wdata,
    input  dbus_ack, dbus_rdata
  );

  modport slave (
    input  dbus_req, dbus_we, dbus_be, dbus_addr, dbus_wdata,
    output dbus_ack, dbus_rdata
  );
endinterface

// File: rtl/mem_stage_ctrl.sv
// MEM stage plus MEM/WB register of MiniMIPS32.
// Takes the mem_* bundle from the EXE/MEM register, runs loads/stores on the
// data bus with a req/ack handshake, size-extends load data and presents
// registered write-back info. Holds upstream (stall_req) while an access is
// pending.
//  cpu_clk_50M / cpu_rst_n   clock, async active-low reset
//  mem_aluop/wa/wreg/wd/din  instruction bundle (wd = ALU result / address)
//  stall_req                 combinational hold request to upstream stages
//  dbus                      data bus (master side)
//  wb_wa/wb_wreg/wb_wd       registered write-back info
//  exc_adel/exc_ades         1-cycle pulses on misaligned load/store
//  bus_err                   1-cycle pulse when an access times out
module mem_stage_ctrl #(
  parameter int ALUOP_W = 8,
  parameter int TIMEOUT = 255
) (
  input  logic               cpu_clk_50M,
  input  logic               cpu_rst_n,
  input  logic [ALUOP_W-1:0] mem_aluop,
  input  logic [4:0]         mem_wa,
  input  logic               mem_wreg,
  input  logic [31:0]        mem_wd,
  input  logic [31:0]        mem_din,
  output logic               stall_req,
  mem_stage_ctrl_if.master   dbus,
  output logic [4:0]         wb_wa,
  output logic               wb_wreg,
  output logic [31:0]        wb_wd,
  output logic               exc_adel,
  output logic               exc_ades,
  output logic               bus_err
);

  localparam logic [ALUOP_W-1:0] OP_LB  = ALUOP_W'(8'h90);
  localparam logic [ALUOP_W-1:0] OP_LBU = ALUOP_W'(8'h91);
  localparam logic [ALUOP_W-1:0] OP_LH  = ALUOP_W'(8'h92);
  localparam logic [ALUOP_W-1:0] OP_LHU = ALUOP_W'(8'h93);
  localparam logic [ALUOP_W-1:0] OP_LW  = ALUOP_W'(8'h94);
  localparam logic [ALUOP_W-1:0] OP_SB  = ALUOP_W'(8'h98);
  localparam logic [ALUOP_W-1:0] OP_SH  = ALUOP_W'(8'h99);
  localparam logic [ALUOP_W-1:0] OP_SW  = ALUOP_W'(8'h9A);

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

  // access size encoding for the captured load
  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;

  state_t      state_q;
  logic [7:0]  cnt_q;
  logic        req_q, we_q;
  logic [3:0]  be_q;
  logic [31:0] addr_q, wdata_q;
  logic        ld_q, sgn_q;
  logic [1:0]  sz_q, off_q;
  logic [4:0]  wb_wa_q;
  logic        wb_wreg_q;
  logic [31:0] wb_wd_q;
  logic        adel_q, ades_q, berr_q;

  // ---------------- decode of the incoming bundle ----------------
  logic        is_load, is_store, is_mem, is_half, is_word, misal;
  logic [1:0]  off;
  logic [3:0]  be_d;
  logic [31:0] wdata_d;
  logic [1:0]  sz_d;
  logic        sgn_d;

  assign off      = mem_wd[1:0];
  assign is_load  = (mem_aluop == OP_LB) || (mem_aluop == OP_LBU) || (mem_aluop == OP_LH) ||
                    (mem_aluop == OP_LHU) || (mem_aluop == OP_LW);
  assign is_store = (mem_aluop == OP_SB) || (mem_aluop == OP_SH) || (mem_aluop == OP_SW);
  assign is_mem   = is_load || is_store;
  assign is_half  = (mem_aluop == OP_LH) || (mem_aluop == OP_LHU) || (mem_aluop == OP_SH);
  assign is_word  = (mem_aluop == OP_LW) || (mem_aluop == OP_SW);
  assign misal    = (is_half && off[0]) || (is_word && (off != 2'b00));
  assign sgn_d    = (mem_aluop == OP_LB) || (mem_aluop == OP_LH);

  always_comb begin
    sz_d = SZ_W;
    if (is_half) sz_d = SZ_H;
    else if (!is_word) sz_d = SZ_B;
  end

  always_comb begin
    be_d    = 4'b1111;
    wdata_d = mem_din;
    if (mem_aluop == OP_SB) begin
      be_d    = 4'b0001 << off;
      wdata_d = {4{mem_din[7:0]}};
    end else if (mem_aluop == OP_SH) begin
      be_d    = off[1] ? 4'b1100 : 4'b0011;
      wdata_d = {2{mem_din[15:0]}};
    end
  end

  // ---------------- load lane select / extension ----------------
  // Uses the captured size/offset so it does not depend on upstream holding.
  logic [7:0]  rd_b;
  logic [15:0] rd_h;
  logic [31:0] ld_data;

  always_comb begin
    rd_b = dbus.dbus_rdata[7:0];
    case (off_q)
      2'd1:    rd_b = dbus.dbus_rdata[15:8];
      2'd2:    rd_b = dbus.dbus_rdata[23:16];
      2'd3:    rd_b = dbus.dbus_rdata[31:24];
      default: rd_b = dbus.dbus_rdata[7:0];
    endcase
    rd_h = off_q[1] ? dbus.dbus_rdata[31:16] : dbus.dbus_rdata[15:0];
    case (sz_q)
      SZ_B:    ld_data = {{24{sgn_q & rd_b[7]}}, rd_b};
      SZ_H:    ld_data = {{16{sgn_q & rd_h[15]}}, rd_h};
      default: ld_data = dbus.dbus_rdata;
    endcase
  end

  // Gated by reset so upstream is released the moment reset asserts, even
  // if a memory op is still sitting on the mem_* inputs.
  assign stall_req = cpu_rst_n &&
                     ((state_q == WAIT) || ((state_q == IDLE) && is_mem && !misal));

  // ---------------- FSM + registers ----------------
  always_ff @(posedge cpu_clk_50M or negedge cpu_rst_n) begin
    if (!cpu_rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      req_q     <= 1'b0;
      we_q      <= 1'b0;
      be_q      <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      ld_q      <= 1'b0;
      sgn_q     <= 1'b0;
      sz_q      <= SZ_B;
      off_q     <= '0;
      wb_wa_q   <= '0;
      wb_wreg_q <= 1'b0;
      wb_wd_q   <= '0;
      adel_q    <= 1'b0;
      ades_q    <= 1'b0;
      berr_q    <= 1'b0;
    end else begin
      adel_q <= 1'b0;
      ades_q <= 1'b0;
      berr_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (!is_mem) begin
            wb_wa_q   <= mem_wa;
            wb_wreg_q <= mem_wreg;
            wb_wd_q   <= mem_wd;
          end else if (misal) begin
            adel_q    <= is_load;
            ades_q    <= is_store;
            wb_wreg_q <= 1'b0;
          end else begin
            req_q     <= 1'b1;
            we_q      <= is_store;
            be_q      <= be_d;
            addr_q    <= {mem_wd[31:2], 2'b00};
            wdata_q   <= wdata_d;
            ld_q      <= is_load;
            sgn_q     <= sgn_d;
            sz_q      <= sz_d;
            off_q     <= off;
            cnt_q     <= '0;
            // previous instruction already had its write-back cycle
            wb_wreg_q <= 1'b0;
            state_q   <= WAIT;
          end
        end
        WAIT: begin
          if (req_q && dbus.dbus_ack) begin
            req_q   <= 1'b0;
            state_q <= DONE;
            if (ld_q) begin
              wb_wa_q   <= mem_wa;
              wb_wreg_q <= mem_wreg;
              wb_wd_q   <= ld_data;
            end else begin
              wb_wreg_q <= 1'b0;
            end
          end else if (cnt_q == CNT_LAST) begin
            req_q     <= 1'b0;
            berr_q    <= 1'b1;
            wb_wreg_q <= 1'b0;
            state_q   <= DONE;
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
        DONE: begin
          // the held instruction advances upstream now; it is not re-issued
          wb_wreg_q <= 1'b0;
          state_q   <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign dbus.dbus_req   = req_q;
  assign dbus.dbus_we    = we_q;
  assign dbus.dbus_be    = be_q;
  assign dbus.dbus_addr  = addr_q;
  assign dbus.dbus_wdata = wdata_q;

  assign wb_wa    = wb_wa_q;
  assign wb_wreg  = wb_wreg_q;
  assign wb_wd    = wb_wd_q;
  assign exc_adel = adel_q;
  assign exc_ades = ades_q;
  assign bus_err  = berr_q;

endmodule

// File: tb/tb_mem_stage_ctrl.sv
module tb_mem_stage_ctrl;
  localparam logic [7:0] ADD = 8'h18;
  localparam logic [7:0] LB  = 8'h90;
  localparam logic [7:0] LBU = 8'h91;
  localparam logic [7:0] LH  = 8'h92;
  localparam logic [7:0] LHU = 8'h93;
  localparam logic [7:0] LW  = 8'h94;
  localparam logic [7:0] SB  = 8'h98;
  localparam logic [7:0] SH  = 8'h99;
  localparam logic [7:0] SW  = 8'h9A;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  mem_aluop;
  logic [4:0]  mem_wa;
  logic        mem_wreg;
  logic [31:0] mem_wd, mem_din;
  logic        stall_req;
  logic [4:0]  wb_wa;
  logic        wb_wreg;
  logic [31:0] wb_wd;
  logic        exc_adel, exc_ades, bus_err;

  int checks = 0;
  int errors = 0;
  logic [36:0] sb_q[$];  // {wa, wd} expected on each wb_wreg cycle

  mem_stage_ctrl_if bus ();

  mem_stage_ctrl #(.ALUOP_W(8), .TIMEOUT(8)) dut (
    .cpu_clk_50M(clk), .cpu_rst_n(rst_n),
    .mem_aluop(mem_aluop), .mem_wa(mem_wa), .mem_wreg(mem_wreg),
    .mem_wd(mem_wd), .mem_din(mem_din), .stall_req(stall_req),
    .dbus(bus.master),
    .wb_wa(wb_wa), .wb_wreg(wb_wreg), .wb_wd(wb_wd),
    .exc_adel(exc_adel), .exc_ades(exc_ades), .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every write-back cycle must match the next queued expectation.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && wb_wreg === 1'b1) begin
      checks++;
      if (sb_q.size() == 0) begin
        errors++;
        $error("FAIL wb_unexpected observed=%0h expected=none", {wb_wa, wb_wd});
      end else begin
        logic [36:0] e;
        e = sb_q.pop_front();
        assert ({wb_wa, wb_wd} === e) else begin
          errors++;
          $error("FAIL wb_data observed=%0h expected=%0h", {wb_wa, wb_wd}, e);
        end
      end
    end
  end

  task automatic bubble();
    mem_aluop = ADD; mem_wa = '0; mem_wreg = 1'b0; mem_wd = '0; mem_din = '0;
  endtask

  // Aligned memory op: ack is raised in WAIT cycle ack_n (1-based).
  task automatic mem_op(input string tag, input logic [7:0] op, input logic [31:0] addr,
                        input logic [31:0] din, input logic [4:0] wa, input int ack_n,
                        input logic [31:0] rdata, input logic [3:0] exp_be,
                        input logic [31:0] exp_wdata, input logic exp_we,
                        input logic push, input logic [31:0] exp_wd);
    int stall_cnt;
    mem_aluop = op; mem_wd = addr; mem_din = din; mem_wa = wa; mem_wreg = 1'b1;
    if (push) sb_q.push_back({wa, exp_wd});
    stall_cnt = 0;
    #1;
    if (stall_req === 1'b1) stall_cnt++;
    @(posedge clk); #1;
    check({tag, "_req"}, 32'(bus.dbus_req), 32'd1);
    check({tag, "_addr"}, bus.dbus_addr, {addr[31:2], 2'b00});
    check({tag, "_be"}, 32'(bus.dbus_be), 32'(exp_be));
    check({tag, "_we"}, 32'(bus.dbus_we), 32'(exp_we));
    if (exp_we) check({tag, "_wdata"}, bus.dbus_wdata, exp_wdata);
    for (int i = 1; i <= ack_n; i++) begin
      if (stall_req === 1'b1) stall_cnt++;
      if (i == ack_n) begin bus.dbus_ack = 1'b1; bus.dbus_rdata = rdata; end
      @(posedge clk); #1;
    end
    bus.dbus_ack = 1'b0;
    check({tag, "_done_req"}, 32'(bus.dbus_req), 32'd0);
    check({tag, "_done_stall"}, 32'(stall_req), 32'd0);
    check({tag, "_stall_cycles"}, 32'(stall_cnt), 32'(ack_n + 1));
    @(posedge clk); #1;
    bubble();
  endtask

  initial begin
    int n;
    rst_n = 1'b0;
    bubble();
    bus.dbus_ack = 1'b0; bus.dbus_rdata = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_req", 32'(bus.dbus_req), 32'd0);
    check("rst_wb", {wb_wreg, wb_wa, wb_wd[25:0]}, 32'd0);
    check("rst_exc", {29'd0, exc_adel, exc_ades, bus_err}, 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // non-memory op, latency 1
    mem_aluop = ADD; mem_wa = 5'd5; mem_wreg = 1'b1; mem_wd = 32'h1234;
    sb_q.push_back({5'd5, 32'h1234});
    #1 check("add_stall", 32'(stall_req), 32'd0);
    @(posedge clk); #1;
    check("add_wd", wb_wd, 32'h1234);
    check("add_wa", 32'(wb_wa), 32'd5);
    check("add_wreg", 32'(wb_wreg), 32'd1);
    bubble();

    mem_op("lw",  LW,  32'h100, 0, 5'd3, 3, 32'hDEADBEEF, 4'hF, 0, 1'b0, 1'b1, 32'hDEADBEEF);
    mem_op("lb",  LB,  32'h103, 0, 5'd4, 1, 32'h80000000, 4'hF, 0, 1'b0, 1'b1, 32'hFFFFFF80);
    mem_op("lbu", LBU, 32'h103, 0, 5'd6, 1, 32'h80000000, 4'hF, 0, 1'b0, 1'b1, 32'h00000080);
    mem_op("lh",  LH,  32'h102, 0, 5'd7, 2, 32'h80011234, 4'hF, 0, 1'b0, 1'b1, 32'hFFFF8001);
    mem_op("lhu", LHU, 32'h100, 0, 5'd8, 2, 32'h12348765, 4'hF, 0, 1'b0, 1'b1, 32'h00008765);
    mem_op("sh",  SH,  32'h102, 32'h0000ABCD, 5'd9, 2, 0, 4'b1100, 32'hABCDABCD, 1'b1, 1'b0, 0);
    mem_op("sb",  SB,  32'h101, 32'h0000005A, 5'd9, 1, 0, 4'b0010, 32'h5A5A5A5A, 1'b1, 1'b0, 0);
    mem_op("sw",  SW,  32'h104, 32'h11223344, 5'd9, 1, 0, 4'b1111, 32'h11223344, 1'b1, 1'b0, 0);

    // misaligned store
    mem_aluop = SH; mem_wd = 32'h101; mem_din = 32'hABCD; mem_wreg = 1'b1;
    #1 check("sh_mis_stall", 32'(stall_req), 32'd0);
    @(posedge clk); #1;
    check("sh_mis_ades", 32'(exc_ades), 32'd1);
    check("sh_mis_adel", 32'(exc_adel), 32'd0);
    check("sh_mis_req", 32'(bus.dbus_req), 32'd0);
    bubble();
    @(posedge clk); #1;
    check("sh_mis_pulse", 32'(exc_ades), 32'd0);

    // misaligned load
    mem_aluop = LW; mem_wd = 32'h102; mem_wa = 5'd10; mem_wreg = 1'b1;
    #1 check("lw_mis_stall", 32'(stall_req), 32'd0);
    @(posedge clk); #1;
    check("lw_mis_adel", 32'(exc_adel), 32'd1);
    check("lw_mis_req", 32'(bus.dbus_req), 32'd0);
    bubble();
    @(posedge clk); #1;
    check("lw_mis_pulse", 32'(exc_adel), 32'd0);

    // store that is never acked
    mem_aluop = SW; mem_wd = 32'h200; mem_din = 32'hCAFE; mem_wa = 5'd11; mem_wreg = 1'b1;
    @(posedge clk); #1;
    n = 0;
    while (bus.dbus_req === 1'b1 && n < 50) begin
      n++;
      @(posedge clk); #1;
    end
    check("to_wait_cycles", 32'(n), 32'd8);
    check("to_bus_err", 32'(bus_err), 32'd1);
    check("to_stall", 32'(stall_req), 32'd0);
    @(posedge clk); #1;
    bubble();
    check("to_err_pulse", 32'(bus_err), 32'd0);

    // FSM back in IDLE: plain op goes straight through
    mem_aluop = ADD; mem_wa = 5'd7; mem_wreg = 1'b1; mem_wd = 32'h77;
    sb_q.push_back({5'd7, 32'h77});
    @(posedge clk); #1;
    check("post_to_wd", wb_wd, 32'h77);
    bubble();

    // stray ack outside WAIT must not disturb anything
    bus.dbus_ack = 1'b1;
    @(posedge clk); #1;
    bus.dbus_ack = 1'b0;
    check("stray_ack_req", 32'(bus.dbus_req), 32'd0);

    // async reset in the middle of an access
    mem_aluop = LW; mem_wd = 32'h300; mem_wa = 5'd12; mem_wreg = 1'b1;
    @(posedge clk); #1;
    check("rstw_req_before", 32'(bus.dbus_req), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("rstw_req", 32'(bus.dbus_req), 32'd0);
    check("rstw_stall", 32'(stall_req), 32'd0);
    check("rstw_wb", {wb_wreg, wb_wa, wb_wd[25:0]}, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    check("sb_empty", 32'(sb_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
